// File: rtl/op_decode_pkg.sv
// Shared TIS-100 node ISA definitions: op code fields, enums, control codes,
// and the combinational decode/saturation helpers used by the decoder.
package op_decode_pkg;

  localparam int OPCODE_MSB = 20;
  localparam int OPCODE_LSB = 17;
  localparam int SRC_MSB    = 16;
  localparam int SRC_LSB    = 14;
  localparam int DST_MSB    = 13;
  localparam int DST_LSB    = 11;
  localparam int IMM_MSB    = 10;
  localparam int TARGET_MSB = 3;
  localparam int CONST_MAX  = 999;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3,
    OP_ADD = 4'd4, OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7,
    OP_JEZ = 4'd8, OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11,
    OP_JRO = 4'd12
  } opcode_e;

  typedef enum logic [2:0] {
    SRC_CONST, SRC_ACC, SRC_NIL, SRC_LEFT, SRC_RIGHT, SRC_UP, SRC_DOWN, SRC_ANY
  } src_e;

  typedef enum logic [2:0] {
    DST_ACC, DST_NIL, DST_LEFT, DST_RIGHT, DST_UP, DST_DOWN, DST_ANY, DST_RSVD
  } dst_e;

  localparam logic [3:0] PC_NEXT = 4'd0;
  localparam logic [3:0] PC_JMP  = 4'd1;
  localparam logic [3:0] PC_JEZ  = 4'd2;
  localparam logic [3:0] PC_JNZ  = 4'd3;
  localparam logic [3:0] PC_JGZ  = 4'd4;
  localparam logic [3:0] PC_JLZ  = 4'd5;
  localparam logic [3:0] PC_JRO  = 4'd6;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_NEG  = 2'd3;

  localparam logic [1:0] REG_NONE      = 2'd0;
  localparam logic [1:0] REG_WRITE_ACC = 2'd1;
  localparam logic [1:0] REG_SWP       = 2'd2;
  localparam logic [1:0] REG_SAV       = 2'd3;

  localparam logic [1:0] MUX_CONST = 2'd0;
  localparam logic [1:0] MUX_ACC   = 2'd1;
  localparam logic [1:0] MUX_NIL   = 2'd2;
  localparam logic [1:0] MUX_PORT  = 2'd3;

  typedef struct packed {
    logic signed [10:0] const_value;
    logic [3:0]         pc_instr;
    logic [1:0]         alu_instr;
    logic [1:0]         registers_instr;
    logic [1:0]         in_mux_sel;
    logic               out_mux_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    const_value: 11'sd0, pc_instr: PC_NEXT, alu_instr: ALU_PASS,
    registers_instr: REG_NONE, in_mux_sel: MUX_NIL, out_mux_sel: 1'b0
  };

  localparam logic signed [10:0] SAT_HI = 11'(CONST_MAX);
  localparam logic signed [10:0] SAT_LO = -SAT_HI;

  function automatic logic signed [10:0] saturate_imm(input logic signed [10:0] imm);
    if (imm > SAT_HI) return SAT_HI;
    if (imm < SAT_LO) return SAT_LO;
    return imm;
  endfunction

  function automatic logic [1:0] src_to_mux(input src_e src);
    case (src)
      SRC_CONST: return MUX_CONST;
      SRC_ACC:   return MUX_ACC;
      SRC_NIL:   return MUX_NIL;
      default:   return MUX_PORT;
    endcase
  endfunction

  function automatic ctrl_t decode_op(input logic [20:0] op_code);
    ctrl_t              c;
    logic [3:0]         opc;
    src_e               src;
    dst_e               dst;
    logic signed [10:0] imm_const;
    logic signed [10:0] target;
    c         = CTRL_NOP;
    opc       = op_code[OPCODE_MSB:OPCODE_LSB];
    src       = src_e'(op_code[SRC_MSB:SRC_LSB]);
    dst       = dst_e'(op_code[DST_MSB:DST_LSB]);
    imm_const = (src == SRC_CONST) ? saturate_imm($signed(op_code[IMM_MSB:0])) : 11'sd0;
    target    = $signed({7'd0, op_code[TARGET_MSB:0]});
    case (opc)
      OP_MOV: begin
        c.in_mux_sel  = src_to_mux(src);
        c.const_value = imm_const;
        if (dst == DST_ACC) c.registers_instr = REG_WRITE_ACC;
        else if (dst != DST_NIL && dst != DST_RSVD) c.out_mux_sel = 1'b1;
      end
      OP_SWP: c.registers_instr = REG_SWP;
      OP_SAV: c.registers_instr = REG_SAV;
      OP_ADD, OP_SUB: begin
        c.alu_instr       = (opc == OP_ADD) ? ALU_ADD : ALU_SUB;
        c.registers_instr = REG_WRITE_ACC;
        c.in_mux_sel      = src_to_mux(src);
        c.const_value     = imm_const;
      end
      OP_NEG: begin
        c.alu_instr       = ALU_NEG;
        c.registers_instr = REG_WRITE_ACC;
        c.in_mux_sel      = MUX_ACC;
      end
      OP_JMP: begin c.pc_instr = PC_JMP; c.const_value = target; end
      OP_JEZ: begin c.pc_instr = PC_JEZ; c.const_value = target; end
      OP_JNZ: begin c.pc_instr = PC_JNZ; c.const_value = target; end
      OP_JGZ: begin c.pc_instr = PC_JGZ; c.const_value = target; end
      OP_JLZ: begin c.pc_instr = PC_JLZ; c.const_value = target; end
      OP_JRO: begin
        c.pc_instr    = PC_JRO;
        c.in_mux_sel  = src_to_mux(src);
        c.const_value = imm_const;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/op_decode.sv
// TIS-100 node instruction decoder: one register stage between fetch and the
// datapath control inputs.
module op_decode
  import op_decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [20:0]        op_code,
  output logic signed [10:0] const_value,
  output logic [3:0]         pc_instr,
  output logic [1:0]         alu_instr,
  output logic [1:0]         registers_instr,
  output logic [1:0]         in_mux_sel,
  output logic               out_mux_sel
);

  ctrl_t decoded;
  ctrl_t ctrl_q;

  always_comb begin
    decoded = decode_op(op_code);
  end

  // Reset wins over enable so a flush always lands on the NOP vector.
  always_ff @(posedge clk) begin
    if (!rst_n)  ctrl_q <= CTRL_NOP;
    else if (en) ctrl_q <= decoded;
  end

  assign const_value     = ctrl_q.const_value;
  assign pc_instr        = ctrl_q.pc_instr;
  assign alu_instr       = ctrl_q.alu_instr;
  assign registers_instr = ctrl_q.registers_instr;
  assign in_mux_sel      = ctrl_q.in_mux_sel;
  assign out_mux_sel     = ctrl_q.out_mux_sel;

endmodule

// File: tb/tb_op_decode.sv
// Scoreboard bench for op_decode: each driven instruction queues its expected
// control vector, which is compared one edge later.
module tb_op_decode;

  typedef struct {
    string tag;
    int    c;
    int    pc;
    int    alu;
    int    rg;
    int    im;
    int    om;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [20:0]        op_code = '0;
  logic signed [10:0] const_value;
  logic [3:0]         pc_instr;
  logic [1:0]         alu_instr;
  logic [1:0]         registers_instr;
  logic [1:0]         in_mux_sel;
  logic               out_mux_sel;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  op_decode dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op_code(op_code),
    .const_value(const_value), .pc_instr(pc_instr), .alu_instr(alu_instr),
    .registers_instr(registers_instr), .in_mux_sel(in_mux_sel),
    .out_mux_sel(out_mux_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [20:0] mk(input int opc, input int src, input int dst, input int imm);
    logic [31:0] iv;
    logic [31:0] ov;
    logic [31:0] sv;
    logic [31:0] dv;
    iv = imm; ov = opc; sv = src; dv = dst;
    return {ov[3:0], sv[2:0], dv[2:0], iv[10:0]};
  endfunction

  function automatic int clamp(input int v);
    if (v > 999) return 999;
    if (v < -999) return -999;
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic [20:0] op, input int c, input int pc,
                               input int alu, input int rg, input int im, input int om);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; op_code = op;
    x.tag = tag; x.c = c; x.pc = pc; x.alu = alu; x.rg = rg; x.im = im; x.om = om;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      checkOutput({x.tag, ".const"}, int'(const_value), x.c);
      checkOutput({x.tag, ".pc"}, int'(pc_instr), x.pc);
      checkOutput({x.tag, ".alu"}, int'(alu_instr), x.alu);
      checkOutput({x.tag, ".reg"}, int'(registers_instr), x.rg);
      checkOutput({x.tag, ".in_mux"}, int'(in_mux_sel), x.im);
      checkOutput({x.tag, ".out_mux"}, int'(out_mux_sel), x.om);
    end
  end

  initial begin
    logic [10:0] bits;
    int          v;
    int          waited;

    applyStimulus("reset_add_acc", 0, 1, mk(4, 1, 0, 0), 0, 0, 0, 0, 2, 0);
    applyStimulus("mov_5_acc", 1, 1, mk(1, 0, 0, 5), 5, 0, 0, 1, 0, 0);
    applyStimulus("mov_m3_left", 1, 1, mk(1, 0, 2, -3), -3, 0, 0, 0, 0, 1);
    applyStimulus("add_1000", 1, 1, mk(4, 0, 0, 1000), 999, 0, 1, 1, 0, 0);
    applyStimulus("sub_m1024", 1, 1, mk(5, 0, 0, -1024), -999, 0, 2, 1, 0, 0);
    applyStimulus("add_up", 1, 1, mk(4, 5, 0, 77), 0, 0, 1, 1, 3, 0);
    applyStimulus("jgz_13", 1, 1, mk(10, 0, 0, 'h5AD), 13, 4, 0, 0, 2, 0);
    applyStimulus("jro_acc", 1, 1, mk(12, 1, 0, 0), 0, 6, 0, 0, 1, 0);
    applyStimulus("jro_const", 1, 1, mk(12, 0, 0, -2), -2, 6, 0, 0, 0, 0);
    applyStimulus("jmp_0", 1, 1, mk(7, 0, 0, 'h7F0), 0, 1, 0, 0, 2, 0);
    applyStimulus("jlz_15", 1, 1, mk(11, 3, 4, 15), 15, 5, 0, 0, 2, 0);
    applyStimulus("neg", 1, 1, mk(6, 3, 0, 50), 0, 0, 3, 1, 1, 0);
    applyStimulus("swp", 1, 1, mk(2, 0, 0, 9), 0, 0, 0, 2, 2, 0);
    applyStimulus("sav", 1, 1, mk(3, 0, 0, 9), 0, 0, 0, 3, 2, 0);
    applyStimulus("illegal14", 1, 1, mk(14, 0, 0, 500), 0, 0, 0, 0, 2, 0);
    applyStimulus("mov_999_nil", 1, 1, mk(1, 0, 1, 999), 999, 0, 0, 0, 0, 0);
    applyStimulus("mov_m999_rsvd", 1, 1, mk(1, 0, 7, -999), -999, 0, 0, 0, 0, 0);
    applyStimulus("mov_any_down", 1, 1, mk(1, 7, 5, 300), 0, 0, 0, 0, 3, 1);
    applyStimulus("mov_nil_any", 1, 1, mk(1, 2, 6, 0), 0, 0, 0, 0, 2, 1);
    applyStimulus("mov_7_acc", 1, 1, mk(1, 0, 0, 7), 7, 0, 0, 1, 0, 0);
    applyStimulus("hold_a", 1, 0, mk(4, 0, 0, 1000), 7, 0, 0, 1, 0, 0);
    applyStimulus("hold_b", 1, 0, mk(6, 1, 0, 0), 7, 0, 0, 1, 0, 0);
    applyStimulus("sub_acc", 1, 1, mk(5, 1, 0, 0), 0, 0, 2, 1, 1, 0);
    applyStimulus("reset_no_en", 0, 0, mk(1, 0, 0, 5), 0, 0, 0, 0, 2, 0);
    applyStimulus("post_rst_hold", 1, 0, mk(4, 0, 0, 3), 0, 0, 0, 0, 2, 0);
    applyStimulus("mov_9_acc", 1, 1, mk(1, 0, 0, 9), 9, 0, 0, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      bits = 11'($urandom_range(0, 2047));
      v = int'($signed(bits));
      applyStimulus("rand_add", 1, 1, mk(4, 0, 0, v), clamp(v), 0, 1, 1, 0, 0);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checkOutput("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
